// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter, STEP bits per clock.
// LC-3b shift encoding plus rotate-left; registered result with DONE pulse.
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       TYPE,
  input  logic [AMT_W-1:0] AMOUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT
);

  localparam int CLW = $clog2(WIDTH + 1);
  localparam int CW  = (AMT_W > CLW) ? AMT_W : CLW;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW-1:0] WID_C  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_nxt;
  logic [1:0]       op;
  logic [CW-1:0]    rem_x;
  logic [CW-1:0]    k;

  // One step: shift work by min(STEP, rem) with the latched fill rule.
  always_comb begin
    rem_x    = CW'(rem);
    k        = (rem_x > STEP_C) ? STEP_C : rem_x;
    rem_nxt  = rem - AMT_W'(k);
    work_nxt = work;
    unique case (op)
      2'b00: work_nxt = work << k;
      2'b01: work_nxt = work >> k;
      2'b11: work_nxt = WIDTH'($signed(work) >>> k);
      2'b10: work_nxt = (work << k) | (work >> (WID_C - k));
      default: work_nxt = work;
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_nxt = (AMOUNT != '0) ? SHIFT : FIN;
        end
      end
      SHIFT: begin
        if (rem_nxt == '0) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, stepping and result load on entry to FIN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      work <= '0;
      rem  <= '0;
      op   <= 2'b00;
      OUT  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            work <= A;
            rem  <= AMOUNT;
            op   <= TYPE;
            if (AMOUNT == '0) begin
              OUT <= A;
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          rem  <= rem_nxt;
          if (rem_nxt == '0) begin
            OUT <= work_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE);
  assign DONE = (state == FIN);

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: vectors, random ops and reset cases
// against STEP=1 and STEP=4 instances sharing one stimulus.
module tb_iter_shifter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [15:0] A;
  logic [1:0]  TYPE;
  logic [3:0]  AMOUNT;
  logic        busy1, done1, busy4, done4;
  logic [15:0] out1, out4;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  iter_shifter #(.WIDTH(16), .AMT_W(4), .STEP(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START), .A(A),
    .TYPE(TYPE), .AMOUNT(AMOUNT),
    .BUSY(busy1), .DONE(done1), .OUT(out1)
  );

  iter_shifter #(.WIDTH(16), .AMT_W(4), .STEP(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .START(START), .A(A),
    .TYPE(TYPE), .AMOUNT(AMOUNT),
    .BUSY(busy4), .DONE(done4), .OUT(out4)
  );

  typedef struct {
    logic [15:0] a;
    logic [1:0]  t;
    logic [3:0]  amt;
    logic [15:0] exp;
    bit          poke;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [1:0] t,
                                        input int n);
    logic [31:0] dbl;
    logic [15:0] r;
    r = a;
    case (t)
      2'b00: r = (n >= 16) ? 16'h0 : (a << n);
      2'b01: r = (n >= 16) ? 16'h0 : (a >> n);
      2'b11: r = (n >= 16) ? {16{a[15]}} : 16'($signed(a) >>> n);
      default: begin
        dbl = {a, a} << (n % 16);
        r = dbl[31:16];
      end
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [1:0] t,
                       input logic [3:0] amt, input logic [15:0] exp,
                       input bit poke, input string tag);
    int n    = int'(amt);
    int lat1 = n + 1;
    int lat4 = (n + 3) / 4 + 1;
    int lmax = (lat1 > lat4) ? lat1 : lat4;
    int f1 = -1, f4 = -1, c1 = 0, c4 = 0;
    bit b1 = 1'b1, b4 = 1'b1;
    START  = 1'b1;
    A      = a;
    TYPE   = t;
    AMOUNT = amt;
    tick();
    START  = 1'b0;
    A      = 16'($urandom);
    TYPE   = 2'($urandom);
    AMOUNT = 4'($urandom);
    for (int c = 1; c <= lmax + 1; c++) begin
      if (done1) begin
        c1++;
        if (f1 < 0) f1 = c;
      end
      if (done4) begin
        c4++;
        if (f4 < 0) f4 = c;
      end
      if (busy1 !== (c <= lat1)) b1 = 1'b0;
      if (busy4 !== (c <= lat4)) b4 = 1'b0;
      if (poke && c == 1) begin
        START  = 1'b1;
        A      = ~a;
        TYPE   = ~t;
        AMOUNT = 4'hF;
      end else begin
        START = 1'b0;
      end
      if (c <= lmax) tick();
    end
    chk({tag, " out1"}, 32'(out1), 32'(exp));
    chk({tag, " out4"}, 32'(out4), 32'(exp));
    chk({tag, " lat1"}, 32'(f1), 32'(lat1));
    chk({tag, " lat4"}, 32'(f4), 32'(lat4));
    chk({tag, " ndone1"}, 32'(c1), 32'd1);
    chk({tag, " ndone4"}, 32'(c4), 32'd1);
    chk({tag, " busy1"}, 32'(b1), 32'd1);
    chk({tag, " busy4"}, 32'(b4), 32'd1);
  endtask

  initial begin
    int nd;
    logic [15:0] ra;
    logic [1:0]  rt;
    logic [3:0]  rn;

    vecs.push_back('{16'h0004, 2'b00, 4'd1,  16'h0008, 1'b0});
    vecs.push_back('{16'hFFFF, 2'b01, 4'd1,  16'h7FFF, 1'b0});
    vecs.push_back('{16'hFFFE, 2'b11, 4'd1,  16'hFFFF, 1'b0});
    vecs.push_back('{16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h8001, 2'b10, 4'd4,  16'h0018, 1'b0});
    vecs.push_back('{16'h8001, 2'b10, 4'd5,  16'h0030, 1'b1});
    vecs.push_back('{16'h1234, 2'b10, 4'd0,  16'h1234, 1'b0});
    vecs.push_back('{16'h0001, 2'b00, 4'd2,  16'h0004, 1'b0});
    vecs.push_back('{16'hA5C3, 2'b01, 4'd12, 16'h000A, 1'b1});

    RESET  = 1'b1;
    START  = 1'b0;
    A      = 16'h0;
    TYPE   = 2'b00;
    AMOUNT = 4'd0;
    repeat (3) tick();
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst out1",  32'(out1),  32'd0);
    chk("rst busy4", 32'(busy4), 32'd0);
    RESET = 1'b0;
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].t, vecs[i].amt, vecs[i].exp,
            vecs[i].poke, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rt = 2'($urandom);
      rn = 4'($urandom_range(0, 15));
      do_op(ra, rt, rn, model(ra, rt, int'(rn)), (rn != 0) && i[0],
            $sformatf("rnd%0d", i));
    end

    START  = 1'b1;
    A      = 16'hFFFF;
    TYPE   = 2'b00;
    AMOUNT = 4'd10;
    tick();
    START = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort busy1", 32'(busy1), 32'd0);
    chk("abort done1", 32'(done1), 32'd0);
    chk("abort out1",  32'(out1),  32'd0);
    chk("abort busy4", 32'(busy4), 32'd0);
    chk("abort done4", 32'(done4), 32'd0);
    chk("abort out4",  32'(out4),  32'd0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done1 || done4) nd++;
      tick();
    end
    chk("abort late done", 32'(nd), 32'd0);

    START  = 1'b1;
    RESET  = 1'b1;
    A      = 16'h5555;
    AMOUNT = 4'd0;
    tick();
    START = 1'b0;
    RESET = 1'b0;
    chk("rst+start busy1", 32'(busy1), 32'd0);
    chk("rst+start busy4", 32'(busy4), 32'd0);
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      if (done1 || done4) nd++;
      tick();
    end
    chk("rst+start done", 32'(nd), 32'd0);
    chk("rst+start out1", 32'(out1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
